ama_riscv_alu_arbiter: RTL and testbench
========================================

AMA_RISCV_ALU_ARBITER -- requirements
Module: ama_riscv_alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width; only 32 SHALL be supported.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_op_sel  input  4  requester 0 ALU op code, using the shared ALU op encoding.
REQ-007 req0_a, req0_b  input  32 each  requester 0 operands.
REQ-008 req1_valid, req1_ready, req1_op_sel, req1_a, req1_b  same widths and meanings as REQ-004..007, for requester 1.
REQ-009 rsp0_valid  output  1  result for requester 0 is available.
REQ-010 rsp0_ready  input  1  requester 0 consumes the result.
REQ-011 rsp0_data  output  32  result for requester 0.
REQ-012 rsp1_valid, rsp1_ready, rsp1_data  same as REQ-009..011, for requester 1.
REQ-013 busy  output  1  high while a result is held (state RESP).

Function
REQ-014 Block SHALL share one ALU instance between two requesters; at most one operation in flight.
REQ-015 FSM states SHALL be IDLE and RESP; reset state IDLE.
REQ-016 Slot free = state IDLE, or state RESP with the owning rspN_valid and rspN_ready both high this cycle.
REQ-017 With slot free and at least one reqN_valid, exactly one reqN_ready SHALL assert combinationally in that cycle; otherwise both SHALL be 0.
REQ-018 With one valid requester, that requester SHALL be granted.
REQ-019 With both valid, the winner SHALL follow the policy in REQ-029/030.
REQ-020 On grant, ALU output for the granted op_sel/a/b SHALL be registered into the result register, the owner ID recorded, and the state set to RESP; latency SHALL be 1 cycle (rspN_valid high in the cycle after the handshake).
REQ-021 In RESP, only the owner's rspN_valid SHALL be 1; the other SHALL be 0; rspN_data SHALL hold stable until consumed.
REQ-022 Non-owner rspN_data SHALL read 0.
REQ-023 On response handshake with no new grant, the state SHALL return to IDLE next cycle; with a simultaneous grant (REQ-016), the state SHALL stay RESP with the new result and owner (throughput 1 op/cycle).
REQ-024 Undefined op_sel SHALL be accepted normally and SHALL return 0.
REQ-025 reqN_ready SHALL NOT depend on reqN_op_sel or operand values.

Reset
REQ-026 On rst, the next state SHALL be IDLE; rsp0_valid, rsp1_valid, busy SHALL be 0; result register 0; owner 0; round-robin pointer SHALL favour requester 0.
REQ-027 In a cycle with rst high, req0_ready and req1_ready SHALL be 0.
REQ-028 A result held when rst asserts SHALL be discarded and not re-presented.

Configuration
REQ-029 With macro ALU_ARB_RR_EN defined: round-robin; on contention the requester not granted most recently SHALL win; the pointer SHALL update only on a grant.
REQ-030 Without ALU_ARB_RR_EN: fixed priority; requester 0 SHALL always win contention, and no pointer register SHALL exist.

Structure
REQ-031 ALU op codes, FSM state encodings and requester ID constants SHALL live in the shared defines package with the existing ALU op macros.
REQ-032 The existing ama_riscv_alu SHALL be instantiated as the only sub-module, with operands muxed by the grant.

Verification
REQ-033 Single request: req0 ADD a=5, b=7 -> req0_ready=1 same cycle; next cycle rsp0_valid=1, rsp0_data=12, rsp1_valid=0.
REQ-034 Contention, RR_EN: both valid every cycle, rsp always ready, req0 SUB 10-3 and req1 SLL 1<<4 -> grants alternate 0,1,0,1; data 7 and 16.
REQ-035 Contention, no RR_EN: same stimulus as REQ-034 -> req0 granted every cycle; req1_ready stays 0.
REQ-036 Backpressure: req1 SRA a=0x80000000, b=4 with rsp1_ready=0 for 3 cycles -> rsp1_data=0xF8000000 held stable; req0_ready=0 throughout; grant resumes on the handshake cycle.
REQ-037 Invalid op_sel=4'hF, a=b=0xFFFFFFFF -> accepted; rsp data=0.
REQ-038 rst asserted while in RESP with rsp0_valid=1 -> next cycle rsp0_valid=0, busy=0, state IDLE; a later contention under RR_EN grants req0 first.

Source files
------------

// File: rtl/ama_riscv_alu_arbiter_pkg.sv
// rtl/ama_riscv_alu_arbiter_pkg.sv - shared ALU op codes, arbiter FSM states and requester IDs
package ama_riscv_alu_arbiter_pkg;

  // ALU op encoding: {funct7[5], funct3}; codes not listed here yield 0
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  // Arbiter FSM: IDLE = no result held, RESP = result held for its owner
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_RESP = 1'b1
  } arb_state_t;

  // Requester IDs used for the owner register and round-robin pointer
  localparam logic REQ_ID_0 = 1'b0;
  localparam logic REQ_ID_1 = 1'b1;

endpackage

// File: rtl/ama_riscv_alu.sv
// rtl/ama_riscv_alu.sv - combinational RV32 integer ALU
module ama_riscv_alu
  import ama_riscv_alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        op_sel,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  // Decode op code; unknown codes produce 0 rather than X
  always_comb begin
    result = '0;
    case (op_sel)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $signed(a) >>> shamt;
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/ama_riscv_alu_arbiter.sv
// rtl/ama_riscv_alu_arbiter.sv - two-requester arbiter sharing one ALU; ALU_ARB_RR_EN selects round-robin
module ama_riscv_alu_arbiter
  import ama_riscv_alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_op_sel,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_op_sel,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              busy
);

  arb_state_t        state;
  logic              owner;
  logic [DATA_W-1:0] result;

  logic              rsp_hs;
  logic              slot_free;
  logic              gnt0;
  logic              gnt1;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_out;

`ifdef ALU_ARB_RR_EN
  // Requester favoured on the next contention
  logic              rr_ptr;
`endif

  // Response side is decoded straight from the state and owner registers
  assign busy       = (state == ARB_RESP);
  assign rsp0_valid = (state == ARB_RESP) && (owner == REQ_ID_0);
  assign rsp1_valid = (state == ARB_RESP) && (owner == REQ_ID_1);
  assign rsp0_data  = rsp0_valid ? result : '0;
  assign rsp1_data  = rsp1_valid ? result : '0;

  // The held result leaving this cycle frees the slot for a same-cycle grant
  assign rsp_hs    = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
  assign slot_free = (state == ARB_IDLE) || rsp_hs;

  // Grant selection: depends only on valids, slot state and the policy
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && slot_free) begin
      if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
        gnt0 = (rr_ptr == REQ_ID_0);
        gnt1 = (rr_ptr == REQ_ID_1);
`else
        gnt0 = 1'b1;
`endif
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Operands follow the grant; requester 0 drives the ALU when nobody is granted
  assign alu_op = gnt1 ? req1_op_sel : req0_op_sel;
  assign alu_a  = gnt1 ? req1_a      : req0_a;
  assign alu_b  = gnt1 ? req1_b      : req0_b;

  ama_riscv_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op_sel (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_out)
  );

  // FSM: capture result on grant, release to IDLE on a handshake without a new grant
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ARB_IDLE;
      owner  <= REQ_ID_0;
      result <= '0;
    end else if (gnt0 || gnt1) begin
      state  <= ARB_RESP;
      owner  <= gnt1 ? REQ_ID_1 : REQ_ID_0;
      result <= alu_out;
    end else if (rsp_hs) begin
      state  <= ARB_IDLE;
    end
  end

`ifdef ALU_ARB_RR_EN
  // Round-robin pointer: after a grant, favour the other requester
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= REQ_ID_0;
    end else if (gnt0 || gnt1) begin
      rr_ptr <= gnt1 ? REQ_ID_0 : REQ_ID_1;
    end
  end
`endif

endmodule

// File: tb/tb_ama_riscv_alu_arbiter.sv
// tb/tb_ama_riscv_alu_arbiter.sv - self-checking bench for the shared-ALU arbiter
module tb_ama_riscv_alu_arbiter;
  import ama_riscv_alu_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op_sel, req1_op_sel;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready, busy;
  logic [31:0] rsp0_data, rsp1_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ama_riscv_alu_arbiter #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op_sel(req0_op_sel),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op_sel(req1_op_sel),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .busy(busy)
  );

`ifdef ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // Reference ALU written from the op definitions
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << sh;
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return 32'($signed(a) >>> sh);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return 32'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_op_sel = 0; req1_op_sel = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle_inputs();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; req0_valid = 1; req1_valid = 1;
    #2;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready});
    end
    tick();
    #2;
    checks++;
    if ({rsp0_valid, rsp1_valid, busy} !== 3'b000 || rsp0_data !== 0 || rsp1_data !== 0) begin
      errors++; $display("FAIL reset_state got v0v1busy=%b d0=%h d1=%h exp=000 0 0",
                         {rsp0_valid, rsp1_valid, busy}, rsp0_data, rsp1_data);
    end
    rst = 0; idle_inputs();
  endtask

  task automatic test_single();
    req0_valid = 1; req0_op_sel = ALU_ADD; req0_a = 5; req0_b = 7;
    #2;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL single_grant got=%b exp=10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 0; rsp0_ready = 1;
    #2;
    checks++;
    if (rsp0_valid !== 1 || rsp0_data !== 32'd12 || rsp1_valid !== 0 || rsp1_data !== 0 || busy !== 1) begin
      errors++; $display("FAIL single_rsp got v0=%b d0=%0d v1=%b d1=%0d busy=%b exp 1 12 0 0 1",
                         rsp0_valid, rsp0_data, rsp1_valid, rsp1_data, busy);
    end
    tick();
    rsp0_ready = 0;
    #2;
    checks++;
    if ({rsp0_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL single_release got=%b exp=00", {rsp0_valid, busy});
    end
  endtask

  task automatic test_contention();
    int exp_w, prev_w;
    do_reset();
    req0_valid = 1; req0_op_sel = ALU_SUB; req0_a = 10; req0_b = 3;
    req1_valid = 1; req1_op_sel = ALU_SLL; req1_a = 1;  req1_b = 4;
    rsp0_ready = 1; rsp1_ready = 1;
    exp_w = 0; prev_w = -1;
    for (int k = 0; k < 6; k++) begin
      #2;
      checks++;
      if ({req0_ready, req1_ready} !== ((exp_w == 0) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL contention_grant cyc=%0d got=%b exp_winner=%0d", k, {req0_ready, req1_ready}, exp_w);
      end
      if (prev_w >= 0) begin
        checks++;
        if (prev_w == 0 && (rsp0_valid !== 1 || rsp0_data !== 32'd7 || rsp1_valid !== 0)) begin
          errors++; $display("FAIL contention_rsp0 cyc=%0d got v0=%b d0=%0d v1=%b exp 1 7 0", k, rsp0_valid, rsp0_data, rsp1_valid);
        end
        if (prev_w == 1 && (rsp1_valid !== 1 || rsp1_data !== 32'd16 || rsp0_valid !== 0)) begin
          errors++; $display("FAIL contention_rsp1 cyc=%0d got v1=%b d1=%0d v0=%b exp 1 16 0", k, rsp1_valid, rsp1_data, rsp0_valid);
        end
      end
      tick();
      prev_w = exp_w;
      if (RR) exp_w = 1 - exp_w;
    end
    req0_valid = 0; req1_valid = 0;
    tick();
    idle_inputs();
  endtask

  task automatic test_backpressure();
    req1_valid = 1; req1_op_sel = ALU_SRA; req1_a = 32'h8000_0000; req1_b = 4;
    #2;
    checks++;
    if (req1_ready !== 1) begin
      errors++; $display("FAIL bp_grant got=%b exp=1", req1_ready);
    end
    tick();
    req1_valid = 0;
    req0_valid = 1; req0_op_sel = ALU_ADD; req0_a = 1; req0_b = 1;
    for (int k = 0; k < 3; k++) begin
      #2;
      checks++;
      if (rsp1_valid !== 1 || rsp1_data !== 32'hF800_0000 || req0_ready !== 0 || busy !== 1) begin
        errors++; $display("FAIL bp_hold cyc=%0d got v1=%b d1=%h r0=%b busy=%b exp 1 f8000000 0 1",
                           k, rsp1_valid, rsp1_data, req0_ready, busy);
      end
      tick();
    end
    rsp1_ready = 1;
    #2;
    checks++;
    if (req0_ready !== 1 || rsp1_data !== 32'hF800_0000) begin
      errors++; $display("FAIL bp_resume got r0=%b d1=%h exp 1 f8000000", req0_ready, rsp1_data);
    end
    tick();
    req0_valid = 0; rsp1_ready = 0; rsp0_ready = 1;
    #2;
    checks++;
    if (rsp0_valid !== 1 || rsp0_data !== 32'd2 || rsp1_valid !== 0 || rsp1_data !== 0) begin
      errors++; $display("FAIL bp_next got v0=%b d0=%0d v1=%b d1=%h exp 1 2 0 0", rsp0_valid, rsp0_data, rsp1_valid, rsp1_data);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_invalid_op();
    req0_valid = 1; req0_op_sel = 4'hF; req0_a = 32'hFFFF_FFFF; req0_b = 32'hFFFF_FFFF;
    #2;
    checks++;
    if (req0_ready !== 1) begin
      errors++; $display("FAIL invalid_grant got=%b exp=1", req0_ready);
    end
    tick();
    req0_valid = 0; rsp0_ready = 1;
    #2;
    checks++;
    if (rsp0_valid !== 1 || rsp0_data !== 0) begin
      errors++; $display("FAIL invalid_rsp got v0=%b d0=%h exp 1 0", rsp0_valid, rsp0_data);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_in_resp();
    req0_valid = 1; req0_op_sel = ALU_ADD; req0_a = 2; req0_b = 3;
    tick();
    req0_valid = 0;
    #2;
    checks++;
    if (rsp0_valid !== 1 || rsp0_data !== 32'd5) begin
      errors++; $display("FAIL rst_resp_pre got v0=%b d0=%0d exp 1 5", rsp0_valid, rsp0_data);
    end
    rst = 1;
    tick();
    rst = 0;
    #2;
    checks++;
    if ({rsp0_valid, rsp1_valid, busy} !== 3'b000 || rsp0_data !== 0) begin
      errors++; $display("FAIL rst_resp_clear got v0v1busy=%b d0=%h exp 000 0", {rsp0_valid, rsp1_valid, busy}, rsp0_data);
    end
    tick();
    checks++;
    if ({rsp0_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL rst_resp_nore got=%b exp=00", {rsp0_valid, busy});
    end
    req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
    #2;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL rst_resp_first got=%b exp=10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 0; req1_valid = 0;
    tick();
    idle_inputs();
  endtask

  // Random traffic against a transaction-level model: one held result, its owner, last winner
  task automatic test_random();
    bit          m_busy, m_owner;
    int          m_last;
    logic [31:0] m_data;
    bit          free, g0, g1;
    logic [4:0]  exp_flags;
    logic [31:0] e0, e1;
    do_reset();
    m_busy = 0; m_owner = 0; m_data = 0; m_last = 1;
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 39) == 0);
      req0_valid = ($urandom_range(0, 9) < 6);
      req1_valid = ($urandom_range(0, 9) < 6);
      rsp0_ready = ($urandom_range(0, 9) < 6);
      rsp1_ready = ($urandom_range(0, 9) < 6);
      req0_op_sel = 4'($urandom); req1_op_sel = 4'($urandom);
      req0_a = $urandom; req1_a = $urandom;
      req0_b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
      req1_b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
      #2;
      free = !m_busy || (m_owner == 0 ? rsp0_ready : rsp1_ready);
      g0 = 0; g1 = 0;
      if (!rst && free) begin
        if (req0_valid && req1_valid) begin
          if (RR && m_last == 0) g1 = 1; else g0 = 1;
        end else begin
          g0 = req0_valid; g1 = req1_valid;
        end
      end
      exp_flags = {g0, g1, m_busy && m_owner == 0, m_busy && m_owner == 1, m_busy};
      e0 = (m_busy && m_owner == 0) ? m_data : 32'd0;
      e1 = (m_busy && m_owner == 1) ? m_data : 32'd0;
      checks++;
      if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== exp_flags) begin
        errors++; $display("FAIL random_flags cyc=%0d got r0r1v0v1busy=%b exp=%b",
                           k, {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy}, exp_flags);
      end
      checks++;
      if (rsp0_data !== e0 || rsp1_data !== e1) begin
        errors++; $display("FAIL random_data cyc=%0d got d0=%h d1=%h exp d0=%h d1=%h", k, rsp0_data, rsp1_data, e0, e1);
      end
      if (rst) begin
        m_busy = 0; m_owner = 0; m_data = 0; m_last = 1;
      end else if (g0 || g1) begin
        m_busy = 1; m_owner = g1;
        m_data = g1 ? ref_alu(req1_op_sel, req1_a, req1_b) : ref_alu(req0_op_sel, req0_a, req0_b);
        m_last = g1 ? 1 : 0;
      end else if (m_busy && free) begin
        m_busy = 0;
      end
      tick();
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    tick();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_invalid_op();
    test_reset_in_resp();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
